// File: rtl/accum_alu_seq_pkg.sv
// Opcode encodings for the accumulator ALU. The board wrapper imports
// this package too.
package accum_alu_seq_pkg;
   localparam int FUNC_W = 3;

   localparam logic [FUNC_W-1:0] OP_ADD    = 3'b000;
   localparam logic [FUNC_W-1:0] OP_XOR_OR = 3'b001;
   localparam logic [FUNC_W-1:0] OP_LSL    = 3'b010;
   localparam logic [FUNC_W-1:0] OP_LSR    = 3'b011;
   localparam logic [FUNC_W-1:0] OP_MUL    = 3'b100;
   localparam logic [FUNC_W-1:0] OP_LOAD   = 3'b101;
   localparam logic [FUNC_W-1:0] OP_REDUCE = 3'b110;
   localparam logic [FUNC_W-1:0] OP_CLEAR  = 3'b111;
endpackage

// File: rtl/mul_shift_add.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial-product bit per clock.
// done/product show the final iteration so the parent can write on the same edge.
module mul_shift_add #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] part_q, part_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] part_sum;
   logic               last;

   always_comb begin
      part_sum = part_q + (mplier_q[0] ? mcand_q : '0);
      last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      part_d   = part_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (load) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         part_d   = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
      end else if (busy_q) begin
         part_d   = part_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         part_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         part_q   <= part_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   assign busy    = busy_q;
   assign done    = last;
   assign product = part_sum;
endmodule

// File: rtl/accum_alu_seq.sv
// Registered accumulator ALU: operand B is the low half of the accumulator,
// single-cycle ops write on the accept edge, MUL runs WIDTH cycles.
module accum_alu_seq
   import accum_alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   a,
   input  logic [FUNC_W-1:0]  func,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               done_q, done_d;
   logic               accept, mul_load, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   b_op;
   logic [WIDTH:0]     add_sum;

   assign b_op     = result_q[WIDTH-1:0];
   assign accept   = start && !mul_busy;
   assign mul_load = accept && (func == OP_MUL);
   assign add_sum  = {1'b0, a} + {1'b0, b_op};

   mul_shift_add #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (mul_load),
      .a       (a),
      .b       (b_op),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      result_d = result_q;
      done_d   = mul_done || (accept && func != OP_MUL);
      if (accept) begin
         case (func)
            OP_ADD:    result_d = {{(WIDTH-1){1'b0}}, add_sum};
            OP_XOR_OR: result_d = {a | b_op, a ^ b_op};
            OP_LSL:    result_d = result_q << a;
            OP_LSR:    result_d = result_q >> a;
            OP_MUL:    result_d = result_q;
            OP_LOAD:   result_d = {{WIDTH{1'b0}}, a};
            OP_REDUCE: result_d = {{(2*WIDTH-2){1'b0}}, &{a, b_op}, |{a, b_op}};
            OP_CLEAR:  result_d = '0;
            default:   result_d = result_q;
         endcase
      end
      // accept and mul_done never coincide: mul_done implies busy
      if (mul_done) result_d = mul_product;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = mul_busy;
endmodule

// File: tb/tb_accum_alu_seq.sv
// Bench for accum_alu_seq (WIDTH=4): vector table, MUL/reset sequences,
// and randomized ops against an arithmetic reference model.
module tb_accum_alu_seq;
   import accum_alu_seq_pkg::*;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [W-1:0]   a = '0;
   logic [2:0]     func = '0;
   logic           start = 1'b0;
   logic           busy, done;
   logic [2*W-1:0] result;

   int nvec = 0;
   int nfail = 0;
   int model_r = 0;

   typedef struct {
      logic [2:0] func;
      logic [3:0] a;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[9];

   accum_alu_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (a),
      .func    (func),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int ref_next(input int f, input int av, input int r);
      int b;
      b = r % 16;
      case (f)
         0: return av + b;
         1: return ((av | b) * 16) + (av ^ b);
         2: return (av >= 8) ? 0 : ((r * (1 << av)) % 256);
         3: return (av >= 8) ? 0 : (r / (1 << av));
         4: return av * b;
         5: return av;
         6: return ((av == 15 && b == 15) ? 2 : 0) + ((av != 0 || b != 0) ? 1 : 0);
         default: return 0;
      endcase
   endfunction

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         start = 1'b1; func = vecs[i].func; a = vecs[i].a;
         step();
         chk($sformatf("vec%0d result", i), int'(result), int'(vecs[i].exp));
         chk($sformatf("vec%0d done", i), int'(done), 1);
      end
      start = 1'b0;
      step();
      chk("done falls after ops", int'(done), 0);
   endtask

   initial begin
      vecs[0] = '{OP_LOAD,   4'hB, 8'h0B};
      vecs[1] = '{OP_ADD,    4'h7, 8'h12};
      vecs[2] = '{OP_XOR_OR, 4'h5, 8'h77};
      vecs[3] = '{OP_REDUCE, 4'hF, 8'h01};
      vecs[4] = '{OP_LOAD,   4'hF, 8'h0F};
      vecs[5] = '{OP_LSL,    4'h2, 8'h0C};
      vecs[6] = '{OP_LSR,    4'h9, 8'h00};
      vecs[7] = '{OP_LOAD,   4'h9, 8'h09};
      vecs[8] = '{OP_LSR,    4'h1, 8'h04};

      // Reset values and asynchronous reset mid-cycle
      #12 reset_n = 1'b1;
      step();
      chk("reset result", int'(result), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      start = 1'b1; func = OP_LOAD; a = 4'h6;
      step();
      start = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("async reset result", int'(result), 0);
      chk("async reset done", int'(done), 0);
      chk("async reset busy", int'(busy), 0);
      #3 reset_n = 1'b1;
      step();

      run_vecs(0, 4);

      // MUL 0xD * 0xF with an ignored CLEAR while busy
      start = 1'b1; func = OP_MUL; a = 4'hD;
      step();
      func = OP_CLEAR; a = 4'h0;
      for (int c = 0; c < W; c++) begin
         chk($sformatf("mul busy c%0d", c), int'(busy), 1);
         chk($sformatf("mul hold c%0d", c), int'(result), 8'h0F);
         chk($sformatf("mul no done c%0d", c), int'(done), 0);
         step();
      end
      chk("mul end busy", int'(busy), 0);
      chk("mul result", int'(result), 8'hC3);
      chk("mul done", int'(done), 1);
      start = 1'b0;
      step();
      chk("mul done pulse once", int'(done), 0);
      chk("clear at k+W ignored", int'(result), 8'hC3);

      run_vecs(5, 8);

      // Reset during the second busy cycle aborts the multiply
      start = 1'b1; func = OP_MUL; a = 4'h3;
      step();
      start = 1'b0;
      step();
      chk("abort pre busy", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort busy", int'(busy), 0);
      chk("abort result", int'(result), 0);
      chk("abort done", int'(done), 0);
      #3 reset_n = 1'b1;
      for (int c = 0; c < W + 2; c++) begin
         step();
         chk($sformatf("abort no done c%0d", c), int'(done), 0);
         chk($sformatf("abort busy c%0d", c), int'(busy), 0);
      end
      chk("abort result after", int'(result), 0);

      // Randomized ops against the reference model
      model_r = 0;
      for (int n = 0; n < 150; n++) begin
         int f, av, busy_cnt;
         bit got;
         f  = int'($urandom_range(0, 7));
         av = int'($urandom_range(0, 15));
         start = 1'b1; func = 3'(f); a = 4'(av);
         step();
         model_r = ref_next(f, av, model_r) % 256;
         if (f == 4) begin
            busy_cnt = 0; got = 1'b0;
            for (int c = 0; c < W + 3 && !got; c++) begin
               if (busy) busy_cnt++;
               start = 1'($urandom_range(0, 1));
               func  = 3'($urandom_range(0, 7));
               a     = 4'($urandom_range(0, 15));
               step();
               got = done;
            end
            start = 1'b0;
            chk("rnd mul done seen", int'(got), 1);
            chk("rnd mul busy cycles", busy_cnt, W);
         end else begin
            start = 1'b0;
            chk("rnd done", int'(done), 1);
         end
         chk($sformatf("rnd op%0d a=%0d result", f, av), int'(result), model_r);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/accum_alu_seq.md
Name: accum_alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational lab ALU.
- Holds a 2*WIDTH-bit accumulator. Operand B is always the low WIDTH bits of the accumulator; operand A comes from the input port.
- Adds shift operations and a multi-cycle shift-add multiplier with a start/busy/done handshake.
- The accumulator drives LEDR directly and drives the hex decoders (hex_dis), two nibbles per digit pair.

Parameters:
- WIDTH, 4: operand width in bits. The accumulator and result are 2*WIDTH bits. Legal for WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- a  input  WIDTH  operand A; sampled at the edge where start is accepted
- func  input  3  opcode; sampled with a
- start  input  1  request to execute func; accepted only when busy=0
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when an operation's result is written
- result  output  2*WIDTH  accumulator value

Behaviour:
- Reset: while reset_n=0, asynchronously clear result, busy, done, the multiplier counter and the partial product, independent of clk. Reset mid-multiply aborts it: no done pulse, and result reads 0.
- Accept rule: start=1 and busy=0 at a rising edge. start is ignored while busy=1; it is neither queued nor errored.
- Operand B is result[WIDTH-1:0], taken at the accept edge.
- Opcode 000 ADD: result <= zero-extended (a + B). The carry lands in bit WIDTH.
- Opcode 001 XOR_OR: result <= {zero-ext(a|B), zero-ext(a^B)}. The OR goes in the upper WIDTH bits, the XOR in the lower.
- Opcode 010 LSL: result <= result << a, logical, truncated to 2*WIDTH. A shift of 2*WIDTH or more gives 0.
- Opcode 011 LSR: result <= result >> a, logical, zero fill. A shift of 2*WIDTH or more gives 0.
- Opcode 100 MUL: result <= a * B, unsigned, full 2*WIDTH product. This is the only multi-cycle opcode.
- Opcode 101 LOAD: result <= zero-extended a.
- Opcode 110 REDUCE: result <= {WIDTH+... zeros, &{a,B}, |{a,B}}. Bit 0 is the OR-reduce, bit 1 is the AND-reduce, all upper bits are 0.
- Opcode 111 CLEAR: result <= 0.
- Single-cycle ops:
  - result is updated at the accept edge k.
  - done=1 during the cycle after edge k, then 0 at edge k+1 unless another op completes there.
  - Back-to-back starts on consecutive cycles are legal; each produces its own done pulse, so done stays high continuously.
- MUL sequence:
  - Edge k: latch a and B, set busy=1, clear the counter and the partial product. result is unchanged.
  - Edges k+1 .. k+WIDTH: one shift-add iteration each.
  - Edge k+WIDTH: write result, set busy=0, done=1 for one cycle.
  - busy is therefore high for exactly WIDTH cycles.
  - result holds its pre-MUL value until edge k+WIDTH.
  - A new start is accepted at edge k+WIDTH+1 or later. A start asserted at edge k+WIDTH itself is ignored, because busy=1 is still sampled there.
- func values are fully decoded; there is no undefined opcode.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package: opcode localparams (OP_ADD=3'b000 .. OP_CLEAR=3'b111) and the func width constant. The package is used by this block and the top-level board wrapper.
- One sub-module, mul_shift_add:
  - Parameter WIDTH.
  - Ports: clk, reset_n, load, a, b, busy, done, product.
  - Owns the iteration counter ($clog2(WIDTH+1) bits) and the partial product.
  - The parent only muxes its product into result on its done.
- The datapath for single-cycle ops and the accept/busy control stay in the parent.

Test Plan (WIDTH=4):
- Reset: assert reset_n=0 asynchronously mid-cycle -> result=8'h00, busy=0, done=0 immediately, before the next edge.
- LOAD a=4'hB, then ADD a=4'h7 -> result 8'h0B with a done pulse, then 8'h12 with a done pulse. Back-to-back: done stays high for 2 cycles.
- XOR_OR a=4'h5 with result=8'h12 (B=2) -> result 8'h77. Then REDUCE a=4'hF with B=7 -> 8'h01.
- LOAD 4'hF, then MUL a=4'hD:
  - busy=1 for exactly 4 cycles; result stays 8'h0F throughout.
  - At edge k+4: result=8'hC3, done pulses once.
  - A start pulse with func=CLEAR during busy is ignored.
- result=8'hC3, LSL a=2 -> 8'h0C. LSR a=9 -> 8'h00. LOAD 4'h9 then LSR a=1 -> 8'h04.
- Start MUL, deassert reset_n at cycle 2 of busy -> busy=0, result=0, and no done pulse then or after reset release.
